// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - four-key synchroniser, bounce filter and press/release pulse generator
// Optional key_release output is built when KEY_RELEASE_PULSE_EN is defined.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_in,
    output logic [3:0] key_level,
    output logic [3:0] key_press
`ifdef KEY_RELEASE_PULSE_EN
    ,
    output logic [3:0] key_release
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [CNT_W-1:0] cnt [4];

    // Keys are inverted on entry so everything past the first flop is active-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            key_level <= '0;
            key_press <= '0;
`ifdef KEY_RELEASE_PULSE_EN
            key_release <= '0;
`endif
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= ~key_in;
            s2 <= s1;
            for (int i = 0; i < 4; i++) begin
                key_press[i] <= 1'b0;
`ifdef KEY_RELEASE_PULSE_EN
                key_release[i] <= 1'b0;
`endif
                if (s2[i] == key_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    // Disagreement has persisted long enough: accept the new level.
                    key_level[i] <= s2[i];
                    cnt[i]       <= '0;
                    key_press[i] <= s2[i];
`ifdef KEY_RELEASE_PULSE_EN
                    key_release[i] <= ~s2[i];
`endif
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Four-channel push-button conditioner that sits directly upstream of the LED control block. It takes the raw active-low board keys, synchronises them to `clk`, and filters contact bounce with a per-key stability counter. It then produces a clean active-high pressed level plus a one-cycle press pulse per key. The pulse vector is one-hot when a single key is pressed, which is the form the LED mode logic decodes.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive cycles a synchronised key must differ from its filtered level before the level flips. This is 20 ms at 50 MHz. Legal range is ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: width of each per-key counter.

Ports:
- `clk`  in  1: system clock. The block uses this single clock only.
- `rst`  in  1: reset, synchronous and active-high.
- `key_in`  in  4: raw board keys, active-low (0 = pressed), asynchronous to `clk`.
- `key_level`  out  4: debounced level, active-high (1 = pressed).
- `key_press`  out  4: one-cycle pulse on the debounced 0→1 transition of `key_level`.
- `key_release`  out  4: present only with `KEY_RELEASE_PULSE_EN`. One-cycle pulse on the debounced 1→0 transition.

## Operation
- Each key has an independent channel. Channels share no state.
- **Synchroniser:** two flops per key, `s1 <= ~key_in[i]`, then `s2 <= s1`. The inversion makes all internal logic active-high.
- **Counter rule, evaluated every cycle per key:**
  - If `s2 == key_level[i]`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `key_level[i] <= s2`, `cnt <= 0`, and the matching edge pulse is set for one cycle.
  - Else: `cnt <= cnt + 1`.
- Any disagreement that ends before the counter reaches `DEBOUNCE_CYCLES-1` resets the counter. Bounces and glitches therefore produce no output.
- `key_press[i]` and `key_release[i]` are registered and are high for exactly one cycle per accepted transition. They are never high in consecutive cycles on the same bit.
- Simultaneous presses are handled per key. Multiple bits of `key_press` may assert in the same cycle, and the block does no priority encoding.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so wrap-around cannot occur.

## Timing
- **Reset values:** `s1`, `s2`, `key_level`, `key_press`, `key_release` and every counter are 0. A synchroniser value of 0 means "released".
- **Reset mid-operation:** counters and levels clear on the next edge. A held key is then re-accepted after the full latency. An in-flight pulse is dropped.
- **Latency:** take the first rising edge that samples a new stable `key_in` as edge 1. `key_level` and the pulse update on edge `DEBOUNCE_CYCLES+2`.
- The release path has the same latency as the press path.
- The pulse deasserts on the following edge.
- No input-to-output combinational path exists. All outputs come directly from flops.

## Configuration
- Macro: `KEY_RELEASE_PULSE_EN`.
- **Defined:** the `key_release` port and its pulse register are generated. The pulse fires on every accepted 1→0 transition of `key_level`.
- **Undefined:** the port and its register are absent. Releases still update `key_level` with the same filter and latency.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=16`.
1. **Clean press:** `key_in` goes 4'hF→4'hE and holds. Required: `key_press`=4'b0001 for exactly 1 cycle on edge 18. `key_level`=4'b0001 from edge 18 on. Other bits stay 0.
2. **Bounce:** toggle `key_in[2]` low/high with 5-cycle periods for 60 cycles, then hold low. Required: no pulse during bouncing. A single `key_press`=4'b0100 arrives 18 edges after the final low edge.
3. **Glitch:** `key_in[1]` low for 15 cycles, then high. Required: `key_level` and `key_press` remain 0 throughout.
4. **Simultaneous presses:** `key_in` 4'hF→4'h5 on the same edge. Required: `key_press`=4'b1010 for one cycle on edge 18.
5. **Reset mid-count:** assert `rst` for 1 cycle at count 10 with key 0 held. Required: all outputs 0. The pulse arrives 18 edges after `rst` deasserts, not sooner.
6. **Release with `KEY_RELEASE_PULSE_EN` defined:** release a held key 0. Required: `key_release`=4'b0001 for one cycle on edge 18 and `key_level[0]`→0. Rebuild without the macro and confirm `key_level` behaves identically.
